exc_entry_seq: RTL
==================

// Module: exc_entry_seq
// PURPOSE
//   Sequences exception/interrupt entry and eret exit around CP0 in the 5-stage pipeline.
//   Watches CP0's IntExc and the M-stage eret. Drives the pipeline flush vector, next-PC
//   select/target, the CP0 EXLSet/EXLClr strobes, and a global stall.
//   Defers entry while the memory bridge finishes an M-stage bus cycle.
//   After eret, enforces a guard window so the EPC instruction is fetched before re-entry.
// PARAMETERS
//   HANDLER_ADDR  32'h0000_4180  handler entry PC driven on exception/interrupt entry
//   GUARD_CYCLES  2              cycles after eret during which int_exc is not acted on (0 = none)
//   BUS_TIMEOUT   16             max WAIT_BUS cycles before forced entry (>=1)
// PORTS
//   clk         in   1   system clock, all state on rising edge
//   reset       in   1   asynchronous, active-low; 0 forces IDLE immediately
//   int_exc     in   1   CP0 IntExc (level): pending interrupt or exception at M
//   eret_M      in   1   eret instruction valid in M stage
//   epc         in   32  CP0 EPCout
//   bus_busy    in   1   bridge has an M-stage load/store in flight
//   flush       out  4   {F,D,E,M} stage-register flush, bit3=F .. bit0=M
//   pc_sel      out  2   00 seq/branch, 01 HANDLER_ADDR, 10 epc
//   pc_target   out  32  HANDLER_ADDR when pc_sel=01, epc when 10, else 0
//   exl_set     out  1   one-cycle strobe to CP0 EXLSet
//   exl_clr     out  1   one-cycle strobe to CP0 EXLClr
//   stall_out   out  1   freeze F/D/E (OR'd into hazard stall)
//   in_handler  out  1   1 while state is HANDLER
//   bus_to_err  out  1   one-cycle pulse when BUS_TIMEOUT expires
//   entry_cnt   out  16  saturating count of entries taken (stops at 16'hFFFF)
// BEHAVIOUR
//   States: IDLE, WAIT_BUS, HANDLER, GUARD. Registered state; Mealy outputs from state+inputs.
//   Default outputs: flush=0, pc_sel=00, pc_target=0, all strobes 0, stall_out=0.
//   ENTRY action (same cycle, combinational):
//     flush=4'b1111, pc_sel=01, pc_target=HANDLER_ADDR, exl_set=1.
//     On the edge: next=HANDLER, entry_cnt+=1 (saturating).
//   EXIT action (same cycle): flush=4'b1110 (M not flushed; eret retires),
//     pc_sel=10, pc_target=epc, exl_clr=1.
//     On the edge: next=GUARD with guard_cnt=GUARD_CYCLES-1; if GUARD_CYCLES=0, next=IDLE.
//   IDLE:     int_exc&!bus_busy -> ENTRY.
//             int_exc&bus_busy  -> WAIT_BUS, tmo_cnt=0, stall_out=1.
//             else eret_M       -> EXIT.
//   WAIT_BUS: stall_out=1, no flush. Each cycle: !bus_busy -> ENTRY.
//             tmo_cnt==BUS_TIMEOUT-1 -> ENTRY plus bus_to_err=1 the same cycle.
//             else tmo_cnt+=1. int_exc dropping here -> IDLE, no entry.
//   HANDLER:  in_handler=1. int_exc (nested exception) -> ENTRY again, stays HANDLER.
//             else eret_M -> EXIT.
//   GUARD:    int_exc and eret_M ignored (no outputs).
//             guard_cnt==0 -> IDLE on the edge, else guard_cnt-=1.
//             A still-asserted int_exc is taken from IDLE on the following cycle.
//   Priority: int_exc beats eret_M in every state that acts on both.
//   Reset (async, any time): state=IDLE, guard_cnt=0, tmo_cnt=0, entry_cnt=0; all outputs at defaults.
//   Counters: guard_cnt and tmo_cnt sized $clog2(param+1), never wrap. entry_cnt holds at 16'hFFFF.
//   Latency: entry/exit redirect and flush in the detection cycle. Handler fetch at the next edge.
// TESTING
//   1. IDLE, int_exc=1, bus_busy=0 for 1 cycle -> same cycle flush=1111, pc_sel=01,
//      pc_target=0x4180, exl_set=1; next cycle in_handler=1, entry_cnt=1.
//   2. IDLE, int_exc=1, bus_busy=1 for 3 cycles then 0 -> stall_out=1 for 3 cycles, no flush;
//      entry on cycle 4.
//   3. bus_busy stuck 1, BUS_TIMEOUT=16 -> entry on the 16th WAIT_BUS cycle with bus_to_err=1
//      for exactly 1 cycle.
//   4. HANDLER, eret_M=1, epc=0x3010 -> flush=1110, pc_sel=10, pc_target=0x3010, exl_clr=1.
//      int_exc=1 during the next 2 cycles is ignored; entry taken on cycle 3 if still high.
//   5. HANDLER, int_exc=1 and eret_M=1 together -> ENTRY wins (exl_set=1, exl_clr=0),
//      state stays HANDLER.
//   6. reset driven low mid-WAIT_BUS, asynchronous to clk -> outputs default immediately;
//      after release, IDLE with entry_cnt=0.

Source files
------------

// File: rtl/exc_entry_seq.sv
// exc_entry_seq: sequences exception/interrupt entry and eret exit around CP0 for the 5-stage pipeline.
module exc_entry_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          GUARD_CYCLES = 2,
  parameter int          BUS_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_exc,
  input  logic        eret_M,
  input  logic [31:0] epc,
  input  logic        bus_busy,
  output logic [3:0]  flush,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_target,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        stall_out,
  output logic        in_handler,
  output logic        bus_to_err,
  output logic [15:0] entry_cnt
);
  localparam int GW = GUARD_CYCLES > 0 ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam int TW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD_CYCLES > 0 ? GUARD_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUS_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUS, HANDLER, GUARD} state_t;
  state_t state;
  logic [GW-1:0] guard_cnt;
  logic [TW-1:0] tmo_cnt;
  logic entry, exit_act, to_wait, tmo_last;
  // Outputs are gated by reset so an asserted reset forces defaults even before the state settles.
  always_comb begin
    tmo_last   = tmo_cnt == TMO_LAST;
    entry      = reset && int_exc && ((state == IDLE && !bus_busy) ||
                 (state == WAIT_BUS && (!bus_busy || tmo_last)) || state == HANDLER);
    exit_act   = reset && !int_exc && eret_M && (state == IDLE || state == HANDLER);
    to_wait    = reset && state == IDLE && int_exc && bus_busy;
    bus_to_err = reset && state == WAIT_BUS && int_exc && bus_busy && tmo_last;
    stall_out  = to_wait || (reset && state == WAIT_BUS && int_exc && !entry);
    flush      = entry ? 4'b1111 : exit_act ? 4'b1110 : 4'b0000;
    pc_sel     = entry ? 2'b01 : exit_act ? 2'b10 : 2'b00;
    pc_target  = entry ? HANDLER_ADDR : exit_act ? epc : 32'h0;
    exl_set    = entry;
    exl_clr    = exit_act;
    in_handler = state == HANDLER;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      guard_cnt <= '0;
      tmo_cnt   <= '0;
      entry_cnt <= '0;
    end else begin
      if (entry && entry_cnt != 16'hFFFF) entry_cnt <= entry_cnt + 16'd1;
      if (entry) state <= HANDLER;
      else if (exit_act) begin
        state     <= GUARD_CYCLES == 0 ? IDLE : GUARD;
        guard_cnt <= GUARD_INIT;
      end else if (to_wait) begin
        state   <= WAIT_BUS;
        tmo_cnt <= '0;
      end else if (state == WAIT_BUS) begin
        if (!int_exc) state <= IDLE;
        else tmo_cnt <= tmo_cnt + 1'b1;
      end else if (state == GUARD) begin
        if (guard_cnt == '0) state <= IDLE;
        else guard_cnt <= guard_cnt - 1'b1;
      end
    end
  end
endmodule
